// File: rtl/lost_pkg.sv
// Shared definitions for the signal-transition logger: event word layout and arming length.
// Event word layout, LSB first: changed[NCH], level[NCH], timestamp[TSW].
package lost_pkg;

  localparam int ARM_CYCLES  = 3;
  localparam int EVT_CHG_LSB = 0;

  function automatic int EVT_LVL_LSB(input int nch);
    return nch;
  endfunction

  function automatic int EVT_TS_LSB(input int nch);
    return 2 * nch;
  endfunction

  function automatic int EVT_W(input int nch, input int tsw);
    return tsw + 2 * nch;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event FIFO; a write into a full FIFO is accepted when a read retires the head in the same cycle.
module evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_accept,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_accept,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/transition_capture.sv
// Capture front end: synchronises the monitored lines, timestamps level changes and wrap markers,
// queues them in an event FIFO and mirrors FIFO occupancy on the up/down strobes.
module transition_capture
  import lost_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int TSW   = 24,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       sig_in,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [TSW+2*NCH-1:0] evt_data,
  output logic                 up,
  output logic                 down,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int W       = EVT_W(NCH, TSW);
  localparam int TS_LSB  = EVT_TS_LSB(NCH);
  localparam int LVL_LSB = EVT_LVL_LSB(NCH);

  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] prev;
  logic [TSW-1:0] ts;
  logic [1:0]     arm_cnt;

  logic [NCH-1:0] changed;
  logic           armed;
  logic           evt_gen;
  logic [W-1:0]   evt_word;
  logic [W-1:0]   fifo_dout;
  logic           enq;
  logic           deq;
  logic           fifo_full;
  logic           fifo_empty;
  logic           drop;

  // prev tracks s2 even while disarmed, so lines already high at reset never look like edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      ts      <= '0;
      arm_cnt <= 2'(ARM_CYCLES);
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      prev <= s2;
      ts   <= ts + 1'b1;
      if (arm_cnt != 2'd0) arm_cnt <= arm_cnt - 2'd1;
    end
  end

  assign changed = s2 ^ prev;
  assign armed   = (arm_cnt == 2'd0);
  // A transition in the all-ones cycle doubles as the wrap indication, so one word covers both.
  assign evt_gen = armed && ((changed != '0) || (&ts));

  always_comb begin
    evt_word                         = '0;
    evt_word[TS_LSB +: TSW]          = ts;
    evt_word[LVL_LSB +: NCH]         = s2;
    evt_word[EVT_CHG_LSB +: NCH]     = changed;
  end

  evt_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (evt_gen),
    .wr_data   (evt_word),
    .wr_accept (enq),
    .rd_en     (evt_ready),
    .rd_data   (fifo_dout),
    .rd_accept (deq),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign drop      = evt_gen && fifo_full && !deq;
  assign evt_valid = !fifo_empty;
  assign evt_data  = evt_valid ? fifo_dout : '0;

  // Strobes never overlap: a simultaneous enqueue and dequeue leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up       <= 1'b0;
      down     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      up   <= enq && !deq;
      down <= deq && !enq;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transition_capture.sv
// Directed bench for transition_capture: arming, single event, overflow, full-with-read, reset mid-drain, timestamp wrap.
module tb_transition_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sig_in;
  logic        evt_ready;
  logic        ovf_clr;
  logic        evt_valid;
  logic [39:0] evt_data;
  logic        up;
  logic        down;
  logic        overflow;

  logic [3:0]  sig_in_w;
  logic        ready_w;
  logic        ovf_clr_w;
  logic        evt_valid_w;
  logic [15:0] evt_data_w;
  logic        up_w;
  logic        down_w;
  logic        overflow_w;

  int checks = 0;
  int failures = 0;
  int up_cnt = 0;
  int down_cnt = 0;
  int wrap_cnt = 0;
  logic [15:0] wrap_last = '0;

  always #5 clk = ~clk;

  transition_capture #(.NCH(4), .TSW(24), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .up        (up),
    .down      (down),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  transition_capture #(.NCH(4), .TSW(8), .DEPTH(8)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in_w),
    .evt_valid (evt_valid_w),
    .evt_ready (ready_w),
    .evt_data  (evt_data_w),
    .up        (up_w),
    .down      (down_w),
    .overflow  (overflow_w),
    .ovf_clr   (ovf_clr_w)
  );

  always @(negedge clk) begin
    if (up) up_cnt++;
    if (down) down_cnt++;
    if (evt_valid_w) begin
      wrap_cnt++;
      wrap_last = evt_data_w;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int u0, u1, d0, wc0;

  initial begin
    rst = 1'b1; sig_in = 4'hF; evt_ready = 1'b0; ovf_clr = 1'b0;
    sig_in_w = 4'h0; ready_w = 1'b1; ovf_clr_w = 1'b0;
    tick(3);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_data", 64'(evt_data), 64'd0);
    chk("rst_up", 64'(up), 64'd0);
    chk("rst_down", 64'(down), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Lines high through reset must not produce an event once released.
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("arm_valid", 64'(evt_valid), 64'd0);
      chk("arm_up", 64'(up), 64'd0);
    end

    // Single rising edge on line 2; release edge R gives ts=n after edge R+n.
    rst = 1'b1; sig_in = 4'h0;
    tick(2);
    rst = 1'b0; evt_ready = 1'b1;
    tick(5);
    sig_in = 4'b0100;
    tick(2);
    chk("single_pre_valid", 64'(evt_valid), 64'd0);
    tick(1);
    chk("single_valid", 64'(evt_valid), 64'd1);
    chk("single_chg", 64'(evt_data[3:0]), 64'h4);
    chk("single_lvl", 64'(evt_data[7:4]), 64'h4);
    chk("single_ts", 64'(evt_data[39:8]), 64'd7);
    chk("single_up", 64'(up), 64'd1);
    chk("single_down0", 64'(down), 64'd0);
    tick(1);
    chk("single_drained", 64'(evt_valid), 64'd0);
    chk("single_up_end", 64'(up), 64'd0);
    chk("single_down", 64'(down), 64'd1);
    tick(1);
    chk("single_down_end", 64'(down), 64'd0);

    // Nine transitions into an 8-deep FIFO with the consumer stalled.
    evt_ready = 1'b0;
    u0 = up_cnt;
    for (int i = 0; i < 9; i++) begin
      sig_in[0] = ~sig_in[0];
      tick(2);
    end
    tick(3);
    chk("ovf_ups", 64'(up_cnt - u0), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_valid", 64'(evt_valid), 64'd1);
    chk("ovf_head_chg", 64'(evt_data[3:0]), 64'h1);
    chk("ovf_head_lvl", 64'(evt_data[7:4]), 64'h5);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // New event lands on the same edge the full FIFO retires its head.
    u1 = up_cnt;
    d0 = down_cnt;
    sig_in[0] = ~sig_in[0];
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("fwr_up", 64'(up), 64'd0);
    chk("fwr_down", 64'(down), 64'd0);
    chk("fwr_ovf", 64'(overflow), 64'd0);
    chk("fwr_head_chg", 64'(evt_data[3:0]), 64'h1);
    chk("fwr_head_lvl", 64'(evt_data[7:4]), 64'h4);
    tick(2);
    chk("fwr_ovf_late", 64'(overflow), 64'd0);
    evt_ready = 1'b1;
    tick(10);
    evt_ready = 1'b0;
    chk("drain_downs", 64'(down_cnt - d0), 64'd8);
    chk("drain_ups", 64'(up_cnt - u1), 64'd0);
    chk("drain_empty", 64'(evt_valid), 64'd0);

    // Five events queued, two drained, then reset lands mid-drain.
    for (int i = 0; i < 5; i++) begin
      sig_in[1] = ~sig_in[1];
      tick(2);
    end
    tick(3);
    chk("mid_valid", 64'(evt_valid), 64'd1);
    evt_ready = 1'b1;
    tick(2);
    chk("mid_down", 64'(down), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(evt_valid), 64'd0);
    chk("mid_rst_data", 64'(evt_data), 64'd0);
    chk("mid_rst_up", 64'(up), 64'd0);
    chk("mid_rst_down", 64'(down), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    tick(2);
    rst = 1'b0;
    wc0 = wrap_cnt;
    tick(5);
    chk("post_rst_empty", 64'(evt_valid), 64'd0);
    sig_in[3] = 1'b1;
    tick(3);
    chk("post_rst_valid", 64'(evt_valid), 64'd1);
    chk("post_rst_ts", 64'(evt_data[39:8]), 64'd7);
    chk("post_rst_chg", 64'(evt_data[3:0]), 64'h8);
    chk("post_rst_lvl", 64'(evt_data[7:4]), 64'hE);

    // 8-bit timestamp instance: 600 cycles after release cover exactly two wraps.
    tick(592);
    chk("wrap_count", 64'(wrap_cnt - wc0), 64'd2);
    chk("wrap_word", 64'(wrap_last), 64'hFF00);
    chk("wrap_ovf", 64'(overflow_w), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
